// File: rtl/cam_capture.sv
// Camera byte-stream capture: synchronizes the raw pclk/vsync/href/data bus into clk,
// pairs bytes into RGB444 pixels and emits write strobes with line/pixel coordinates.
module cam_capture #(
  parameter int CAM_DATA_WIDTH = 12,
  parameter int CAM_LINE       = 9,
  parameter int CAM_PIXEL      = 10,
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_DEPTH      = 480
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic                      i_pclk,
  input  logic                      i_vsync,
  input  logic                      i_href,
  input  logic [7:0]                i_cam_data,
  output logic                      o_we,
  output logic [CAM_DATA_WIDTH-1:0] o_data_wr,
  output logic [CAM_LINE-1:0]       o_line,
  output logic [CAM_PIXEL-1:0]      o_pixel,
  output logic                      o_frame_done
);

  typedef enum logic [1:0] {S_SYNC, S_WAIT, S_ACTIVE} state_t;

  localparam logic [CAM_PIXEL-1:0] PIX_MAX  = CAM_PIXEL'(IMG_WIDTH);
  localparam logic [CAM_LINE-1:0]  LINE_MAX = CAM_LINE'(IMG_DEPTH);

  // Data rides the same two flops as the strobes, so a byte is always paired
  // with the pclk edge that launched it: {pclk, vsync, href, data[7:0]}.
  logic [10:0] sync1, sync2;
  logic        pclk_d, vsync_d, href_d;

  logic       pclk_s, vsync_s, href_s;
  logic [7:0] data_s;
  logic       pclk_rise, vsync_rise, vsync_fall, href_fall;

  state_t                   state, state_n;
  logic [CAM_LINE-1:0]      line_cnt, line_n;
  logic [CAM_PIXEL-1:0]     pixel_cnt, pixel_n;
  logic                     toggle, toggle_n;
  logic [3:0]               red, red_n;
  logic                     we_n, done_n;
  logic [CAM_DATA_WIDTH-1:0] data_n;
  logic [CAM_LINE-1:0]      oline_n;
  logic [CAM_PIXEL-1:0]     opixel_n;

  assign pclk_s  = sync2[10];
  assign vsync_s = sync2[9];
  assign href_s  = sync2[8];
  assign data_s  = sync2[7:0];

  assign pclk_rise  = pclk_s & ~pclk_d;
  assign vsync_rise = vsync_s & ~vsync_d;
  assign vsync_fall = ~vsync_s & vsync_d;
  assign href_fall  = ~href_s & href_d;

  // NOTE: every flop here uses non-blocking assignment so all registers sample
  // the same pre-edge values; blocking would make the result order-dependent.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      sync1        <= '0;
      sync2        <= '0;
      pclk_d       <= 1'b0;
      vsync_d      <= 1'b0;
      href_d       <= 1'b0;
      state        <= S_SYNC;
      line_cnt     <= '0;
      pixel_cnt    <= '0;
      toggle       <= 1'b0;
      red          <= '0;
      o_we         <= 1'b0;
      o_data_wr    <= '0;
      o_line       <= '0;
      o_pixel      <= '0;
      o_frame_done <= 1'b0;
    end else begin
      sync1        <= {i_pclk, i_vsync, i_href, i_cam_data};
      sync2        <= sync1;
      pclk_d       <= pclk_s;
      vsync_d      <= vsync_s;
      href_d       <= href_s;
      state        <= state_n;
      line_cnt     <= line_n;
      pixel_cnt    <= pixel_n;
      toggle       <= toggle_n;
      red          <= red_n;
      o_we         <= we_n;
      o_data_wr    <= data_n;
      o_line       <= oline_n;
      o_pixel      <= opixel_n;
      o_frame_done <= done_n;
    end
  end

  // NOTE: each variable gets its hold/idle value first so no path through the
  // decision tree leaves it unassigned, which would infer a latch.
  always_comb begin
    state_n  = state;
    line_n   = line_cnt;
    pixel_n  = pixel_cnt;
    toggle_n = toggle;
    red_n    = red;
    we_n     = 1'b0;
    done_n   = 1'b0;
    data_n   = o_data_wr;
    oline_n  = o_line;
    opixel_n = o_pixel;

    // End of frame wins over any byte arriving in the same cycle.
    if (state != S_SYNC && vsync_rise) begin
      done_n  = 1'b1;
      state_n = S_SYNC;
    end else begin
      case (state)
        S_SYNC: begin
          if (vsync_fall && i_enable) begin
            state_n  = S_WAIT;
            line_n   = '0;
            pixel_n  = '0;
            toggle_n = 1'b0;
          end
        end
        S_WAIT, S_ACTIVE: begin
          if (href_fall) begin
            if (pixel_cnt != '0 && line_cnt < LINE_MAX) line_n = line_cnt + 1'b1;
            pixel_n  = '0;
            toggle_n = 1'b0;
            state_n  = S_WAIT;
          end else if (pclk_rise && href_s) begin
            state_n = S_ACTIVE;
            if (!toggle) begin
              red_n    = data_s[3:0];
              toggle_n = 1'b1;
            end else begin
              toggle_n = 1'b0;
              if (pixel_cnt < PIX_MAX && line_cnt < LINE_MAX) begin
                we_n     = 1'b1;
                data_n   = CAM_DATA_WIDTH'({red, data_s});
                oline_n  = line_cnt;
                opixel_n = pixel_cnt;
              end
              if (pixel_cnt < PIX_MAX) pixel_n = pixel_cnt + 1'b1;
            end
          end
        end
        default: state_n = S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture: stimulus tasks push expected pixels and frame-done
// events; an independent monitor pops and compares whenever the DUT strobes.
module tb_cam_capture;

  // Line width kept at its real 640; frame depth shortened so a full frame fits the run.
  localparam int W = 640;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        i_rst_n, i_enable, i_pclk, i_vsync, i_href;
  logic [7:0]  i_cam_data;
  logic        o_we, o_frame_done;
  logic [11:0] o_data_wr;
  logic [8:0]  o_line;
  logic [9:0]  o_pixel;

  always #5 clk = ~clk;

  cam_capture #(
    .CAM_DATA_WIDTH(12), .CAM_LINE(9), .CAM_PIXEL(10),
    .IMG_WIDTH(W), .IMG_DEPTH(D)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_pclk(i_pclk), .i_vsync(i_vsync), .i_href(i_href), .i_cam_data(i_cam_data),
    .o_we(o_we), .o_data_wr(o_data_wr), .o_line(o_line), .o_pixel(o_pixel),
    .o_frame_done(o_frame_done)
  );

  typedef logic [30:0] px_t;  // {data[11:0], line[8:0], pixel[9:0]}

  px_t  exp_q[$];
  int   done_pending = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_we = 0;

  // Reference model of the capture counters
  int         m_line, m_pix;
  logic       m_tog, m_cap;
  logic [3:0] m_red;
  px_t        m_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor
  initial begin
    logic prev_done;
    px_t  e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_we) begin
        n_we++;
        if (exp_q.size() == 0) check("unexpected_we", 64'(o_we), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("pixel", {o_data_wr, o_line, o_pixel}, e);
        end
      end
      if (o_frame_done) begin
        check("done_width", 64'(prev_done), 64'd0);
        check("done_expected", 64'(done_pending > 0), 64'd1);
        if (done_pending > 0) done_pending--;
      end
      prev_done = o_frame_done;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

  task automatic model_byte(input logic [7:0] b);
    if (m_cap && i_href) begin
      if (!m_tog) begin
        m_red = b[3:0];
        m_tog = 1'b1;
      end else begin
        m_tog = 1'b0;
        if (m_pix < W && m_line < D) begin
          m_last = {m_red, b, 9'(m_line), 10'(m_pix)};
          exp_q.push_back(m_last);
        end
        if (m_pix < W) m_pix++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit measure = 1'b0);
    model_byte(b);
    i_cam_data = b;
    #20;
    if (!measure) begin
      i_pclk = 1'b1;
      #20;
      i_pclk = 1'b0;
    end else begin
      fork
        begin
          i_pclk = 1'b1;
          #20;
          i_pclk = 1'b0;
          #20;
        end
        begin
          int  n;
          bit  found;
          n = 0;
          found = 1'b0;
          for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            if (!found && o_we) begin
              found = 1'b1;
              n = i;
            end
          end
          check("we_latency", 64'(n), 64'd3);
        end
      join
    end
  endtask

  task automatic line_end_model();
    if (m_cap) begin
      if (m_pix > 0 && m_line < D) m_line++;
      m_pix = 0;
      m_tog = 1'b0;
    end
  endtask

  task automatic send_line(input int n_bytes, input bit fixed_pat, input int measure_at = -1);
    i_href = 1'b1;
    #20;
    for (int k = 0; k < n_bytes; k++) begin
      logic [7:0] b;
      if (fixed_pat) b = (k % 2 == 0) ? 8'h0A : 8'hBC;
      else           b = (k % 2 == 0) ? 8'(k * 5 + 3) : 8'(k * 29 + m_line * 3 + 1);
      send_byte(b, k == measure_at);
    end
    #20;
    i_href = 1'b0;
    line_end_model();
    #40;
  endtask

  task automatic frame_begin(input logic en);
    i_enable = en;
    i_vsync  = 1'b0;
    if (en) begin
      m_cap  = 1'b1;
      m_line = 0;
      m_pix  = 0;
      m_tog  = 1'b0;
    end
    #60;
  endtask

  task automatic frame_end();
    if (m_cap) done_pending++;
    m_cap   = 1'b0;
    i_vsync = 1'b1;
    #60;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || done_pending != 0); i++) @(negedge clk);
    check(name, 64'(exp_q.size() + done_pending), 64'd0);
  endtask

  initial begin
    int we_before;
    i_rst_n = 1'b0; i_enable = 1'b0; i_pclk = 1'b0; i_vsync = 1'b1;
    i_href = 1'b0; i_cam_data = 8'h00;
    m_cap = 1'b0; m_line = 0; m_pix = 0; m_tog = 1'b0; m_red = '0; m_last = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_we, o_frame_done, o_data_wr, o_line, o_pixel}, 64'd0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Short frame, latency measured on the first pixel; first pixel is 0x03,0x1E -> 0x31E
    frame_begin(1'b1);
    send_line(6, 1'b0, 1);
    frame_end();
    wait_drain("short_drain");
    check("short_hold", {o_data_wr, o_line, o_pixel}, m_last);

    // Full frame of 0x0A,0xBC pixels
    we_before = n_we;
    frame_begin(1'b1);
    repeat (D) send_line(2 * W, 1'b1);
    frame_end();
    wait_drain("full_drain");
    check("full_writes", 64'(n_we - we_before), 64'(W * D));
    check("full_last", {o_data_wr, o_line, o_pixel}, {12'hABC, 9'(D - 1), 10'(W - 1)});

    // Over-long line: 700 pairs clipped at 640, next line restarts at pixel 0
    we_before = n_we;
    frame_begin(1'b1);
    send_line(1400, 1'b1);
    send_line(4, 1'b0);
    frame_end();
    wait_drain("long_drain");
    check("long_writes", 64'(n_we - we_before), 64'(W + 2));
    check("long_next_line", {o_line, o_pixel}, {9'd1, 10'd1});

    // Line count saturates: lines past the frame depth write nothing
    frame_begin(1'b1);
    repeat (D + 2) send_line(4, 1'b0);
    frame_end();
    wait_drain("depth_drain");
    check("depth_hold", {o_data_wr, o_line, o_pixel}, m_last);

    // Odd byte count: leftover byte discarded
    frame_begin(1'b1);
    send_line(3, 1'b0);
    send_line(4, 1'b0);
    frame_end();
    wait_drain("odd_drain");
    check("odd_hold", {o_data_wr, o_line, o_pixel}, m_last);

    // Disabled at frame start: nothing, no frame_done
    we_before = n_we;
    frame_begin(1'b0);
    send_line(8, 1'b0);
    send_line(8, 1'b0);
    frame_end();
    wait_drain("disabled_drain");
    check("disabled_writes", 64'(n_we - we_before), 64'd0);

    // Enable dropped mid-frame: frame completes
    frame_begin(1'b1);
    send_line(6, 1'b0);
    i_enable = 1'b0;
    send_line(6, 1'b0);
    frame_end();
    wait_drain("en_drop_drain");
    check("en_drop_hold", {o_data_wr, o_line, o_pixel}, m_last);

    // Reset mid-line after 10 pixels
    frame_begin(1'b1);
    i_href = 1'b1;
    #20;
    for (int k = 0; k < 20; k++) send_byte(8'(k * 17 + 2));
    #100;
    check("pre_reset_drain", 64'(exp_q.size()), 64'd0);
    check("pre_reset_pixel", 64'(o_pixel), 64'd9);
    @(negedge clk);
    i_rst_n = 1'b0;
    m_cap = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    check("mid_reset_outputs", {o_we, o_frame_done, o_data_wr, o_line, o_pixel}, 64'd0);
    for (int k = 0; k < 4; k++) send_byte(8'(k + 40));
    #20;
    i_href = 1'b0;
    #40;
    frame_end();
    frame_begin(1'b1);
    send_line(6, 1'b0);
    frame_end();
    wait_drain("post_reset_drain");
    check("post_reset_first_line", {o_line, o_pixel}, {9'd0, 10'd2});

    // vsync rise coincident with a byte1 pclk edge: byte dropped, frame ends
    we_before = n_we;
    frame_begin(1'b1);
    send_line(4, 1'b0);
    i_href = 1'b1;
    #20;
    send_byte(8'h07);
    i_cam_data = 8'hE5;
    #20;
    i_pclk  = 1'b1;
    i_vsync = 1'b1;
    done_pending++;
    m_cap = 1'b0;
    #20;
    i_pclk = 1'b0;
    #20;
    i_href = 1'b0;
    #60;
    send_line(4, 1'b0);  // back in sync-hunt: must not write
    wait_drain("coincident_drain");
    check("coincident_writes", 64'(n_we - we_before), 64'd2);

    repeat (20) @(negedge clk);
    wait_drain("final_drain");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 The block SHALL have parameter CAM_DATA_WIDTH, default 12, meaning output pixel width in RGB444 format.
REQ-002 The block SHALL have parameter CAM_LINE, default 9, meaning line counter width.
REQ-003 The block SHALL have parameter CAM_PIXEL, default 10, meaning pixel counter width.
REQ-004 The block SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line accepted.
REQ-005 The block SHALL have parameter IMG_DEPTH, default 480, meaning lines per frame accepted.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit, meaning a synchronous, active-low reset.
REQ-008 The block SHALL have port i_enable, input, 1 bit, meaning capture is allowed; sampled only at frame start.
REQ-009 The block SHALL have ports i_pclk, i_vsync and i_href, each an input of 1 bit, carrying the raw camera signals, which are asynchronous to clk.
REQ-010 The block SHALL have port i_cam_data, input, 8 bits, meaning the raw camera byte bus.
REQ-011 The block SHALL have port o_we, output, 1 bit, meaning a one-cycle pixel-valid strobe.
REQ-012 The block SHALL have port o_data_wr, output, CAM_DATA_WIDTH bits, meaning the pixel as {R[3:0],G[3:0],B[3:0]}.
REQ-013 The block SHALL have ports o_line (output, CAM_LINE bits) and o_pixel (output, CAM_PIXEL bits), giving the coordinates of the pixel on o_data_wr.
REQ-014 The block SHALL have port o_frame_done, output, 1 bit, meaning a one-cycle pulse at the end of a captured frame.

Function
REQ-015 The block SHALL pass i_pclk, i_vsync, i_href and i_cam_data through the same 2-flop synchronizer, so that the data stays aligned with the strobe.
REQ-016 The block SHALL generate an internal strobe, pclk_rise, for one clk cycle when the synchronized pclk goes from 0 to 1; clk frequency SHALL be at least 3x the pclk frequency.
REQ-017 The block SHALL implement an FSM with states S_SYNC, S_WAIT and S_ACTIVE.
REQ-018 In S_SYNC, on a synchronized vsync falling edge with i_enable=1, the block SHALL go to S_WAIT, clear the line counter, clear the pixel counter and clear the byte toggle; if i_enable=0 it SHALL stay in S_SYNC.
REQ-019 In S_WAIT, when pclk_rise occurs with synchronized href=1, the block SHALL go to S_ACTIVE and treat that byte as byte0.
REQ-020 In S_ACTIVE, byte0 (toggle=0) SHALL latch i_cam_data[3:0] as R; byte1 (toggle=1) SHALL form {R, data[7:4], data[3:0]} and request a write; the toggle SHALL flip on every pclk_rise while href=1.
REQ-021 The block SHALL register o_we high for exactly one clk cycle, starting on the clk edge after the byte1 pclk_rise cycle, so that latency is 3 clk edges from the first edge at which i_pclk is sampled high.
REQ-022 o_data_wr, o_line and o_pixel SHALL be updated on the same edge as o_we and SHALL hold their values until the next write.
REQ-023 After each write, the pixel counter SHALL increment by 1.
REQ-024 Writes with pixel counter >= IMG_WIDTH or line counter >= IMG_DEPTH SHALL be suppressed (o_we stays 0); the counters SHALL saturate and never wrap.
REQ-025 On a synchronized href falling edge: if the pixel counter > 0, the line counter SHALL increment (saturating at IMG_DEPTH); the pixel counter SHALL be cleared, the toggle SHALL be cleared, a pending odd byte0 SHALL be discarded, and the FSM SHALL return to S_WAIT.
REQ-026 On a synchronized vsync rising edge in S_WAIT or S_ACTIVE, the block SHALL pulse o_frame_done for 1 cycle and go to S_SYNC; this event SHALL take priority over a simultaneous pclk_rise, whose byte is dropped.
REQ-027 A frame that is in progress SHALL complete even if i_enable is deasserted mid-frame.
REQ-028 A vsync falling edge seen outside S_SYNC SHALL be ignored.

Reset
REQ-029 While i_rst_n=0 at a clk edge: FSM=S_SYNC; o_we=0, o_frame_done=0, o_data_wr=0, o_line=0, o_pixel=0; all counters, the toggle and the synchronizer flops SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no o_frame_done; after release, capture SHALL restart only at the next vsync falling edge.

Verification
REQ-031 The bench SHALL cover a full frame: enable=1, 640x480 frame, bytes 0x0A,0xBC per pixel -> 307200 o_we pulses with data 0xABC, last at line 479 / pixel 639, then 1 o_frame_done.
REQ-032 The bench SHALL cover an over-long line: 700 pixel pairs in one href -> exactly 640 writes, pixel 0..639; the next line starts at pixel 0, line+1.
REQ-033 The bench SHALL cover an odd byte count: 3 bytes in one href -> 1 write, leftover byte discarded; the next line's first write uses only new bytes.
REQ-034 The bench SHALL cover enable gating: enable=0 at vsync fall -> 0 writes for the whole frame; enable dropped mid-frame -> the frame completes with o_frame_done.
REQ-035 The bench SHALL cover reset mid-line: i_rst_n=0 for 1 cycle after 10 pixels -> all outputs 0 and no o_frame_done; the next frame restarts at line 0 / pixel 0.
REQ-036 The bench SHALL cover simultaneous events: vsync rise in the same cycle as a byte1 pclk_rise -> no write, o_frame_done=1 for exactly 1 cycle, FSM=S_SYNC.
